ethernet_tx_arbiter: RTL and testbench

//  Shares the single host->packet write port of ethernet_sender among num_req_p requesters.

---
 rtl/eth_pkg.sv | 27 ++
 rtl/eth_tx_rr_arb.sv | 30 +++
 rtl/ethernet_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ethernet_tx_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and width helpers for the ethernet_sender TX port arbiter.
package eth_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } eth_tx_state_e;

  localparam int unsigned eth_mtu_default_lp = 2048;

  function automatic int unsigned eth_addr_width(input int unsigned mtu);
    return $clog2(mtu);
  endfunction

  function automatic int unsigned eth_size_width(input int unsigned mtu);
    return $clog2(mtu + 1);
  endfunction

  // Width of the log2(bytes) data size code for a given data bus width.
  function automatic int unsigned eth_dsize_width(input int unsigned data_width);
    return $clog2($clog2(data_width / 8) + 1);
  endfunction

  localparam int unsigned eth_addr_width_default_lp = eth_addr_width(eth_mtu_default_lp);
  localparam int unsigned eth_size_width_default_lp = eth_size_width(eth_mtu_default_lp);

endpackage

// File: rtl/eth_tx_rr_arb.sv
// Round-robin picker: first requester at or after the pointer wins, pointer advances past it.
module eth_tx_rr_arb #(
  parameter  int unsigned num_req_p    = 2,
  localparam int unsigned ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic [num_req_p-1:0]    i_req,
  input  logic [ptr_width_lp-1:0] i_ptr,
  input  logic                    i_en,
  output logic [num_req_p-1:0]    o_grant_c,
  output logic [ptr_width_lp-1:0] o_next_ptr_c,
  output logic                    o_valid_c
);

  always_comb begin
    int unsigned idx;
    idx          = 0;
    o_grant_c    = '0;
    o_next_ptr_c = i_ptr;
    o_valid_c    = 1'b0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = (32'(i_ptr) + k) % num_req_p;
      if (i_en && !o_valid_c && i_req[ptr_width_lp'(idx)]) begin
        o_valid_c                        = 1'b1;
        o_grant_c[ptr_width_lp'(idx)]    = 1'b1;
        o_next_ptr_c                     = ptr_width_lp'((idx + 1) % num_req_p);
      end
    end
  end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// Shares the ethernet_sender packet write port among several requesters, one whole
// packet per grant, round-robin, with a watchdog that revokes a stalled owner.
module ethernet_tx_arbiter
  import eth_pkg::*;
#(
  parameter  int unsigned num_req_p      = 2,
  parameter  int unsigned data_width_p   = 32,
  parameter  int unsigned eth_mtu_p      = 2048,
  parameter  int unsigned timeout_p      = 1024,
  localparam int unsigned addr_width_lp  = eth_addr_width(eth_mtu_p),
  localparam int unsigned size_width_lp  = eth_size_width(eth_mtu_p),
  localparam int unsigned dsize_width_lp = eth_dsize_width(data_width_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p-1:0]                req_v_i,
  output logic [num_req_p-1:0]                grant_o,
  input  logic [num_req_p-1:0]                req_wsize_valid_i,
  input  logic [num_req_p*size_width_lp-1:0]  req_wsize_i,
  input  logic [num_req_p-1:0]                req_wvalid_i,
  input  logic [num_req_p*addr_width_lp-1:0]  req_waddr_i,
  input  logic [num_req_p*data_width_p-1:0]   req_wdata_i,
  input  logic [num_req_p*dsize_width_lp-1:0] req_wdata_size_i,
  input  logic [num_req_p-1:0]                req_send_i,
  input  logic                                packet_req_i,
  output logic                                packet_wsize_valid_o,
  output logic [size_width_lp-1:0]            packet_wsize_o,
  output logic                                packet_wvalid_o,
  output logic [addr_width_lp-1:0]            packet_waddr_o,
  output logic [data_width_p-1:0]             packet_wdata_o,
  output logic [dsize_width_lp-1:0]           packet_wdata_size_o,
  output logic                                packet_send_o,
  output logic                                abort_o,
  output logic [15:0]                         sent_count_o
);

  localparam int unsigned ptr_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int unsigned wd_width_lp  = $clog2(timeout_p);

  eth_tx_state_e             r_state, w_state_nxt;
  logic [num_req_p-1:0]      r_grant, w_grant_nxt;
  logic [ptr_width_lp-1:0]   r_ptr, w_ptr_nxt;
  logic [wd_width_lp-1:0]    r_wdog, w_wdog_nxt;
  logic                      r_abort, w_abort_nxt;
  logic [15:0]               r_sent_count;
  logic                      w_sent_inc;

  logic                      w_arb_en, w_arb_valid;
  logic [num_req_p-1:0]      w_arb_grant;
  logic [ptr_width_lp-1:0]   w_arb_next_ptr;

  logic                      w_own;
  logic                      w_g_req_v, w_g_wsize_v, w_g_wvalid, w_g_send;
  logic [size_width_lp-1:0]  w_g_wsize;
  logic [addr_width_lp-1:0]  w_g_waddr;
  logic [data_width_p-1:0]   w_g_wdata;
  logic [dsize_width_lp-1:0] w_g_dsize;
  logic [num_req_p-1:0]      w_req_strobe;

  eth_tx_rr_arb #(.num_req_p(num_req_p)) u_rr_arb (
    .i_req        (req_v_i),
    .i_ptr        (r_ptr),
    .i_en         (w_arb_en),
    .o_grant_c    (w_arb_grant),
    .o_next_ptr_c (w_arb_next_ptr),
    .o_valid_c    (w_arb_valid)
  );

  assign w_own        = (r_state == OWN);
  assign w_g_req_v    = |(req_v_i & r_grant);
  assign w_g_wsize_v  = |(req_wsize_valid_i & r_grant);
  assign w_g_wvalid   = |(req_wvalid_i & r_grant);
  assign w_g_send     = |(req_send_i & r_grant);
  assign w_req_strobe = req_wsize_valid_i | req_wvalid_i | req_send_i;

  // AND-OR select of the grantee's payload; zero whenever no grant is held.
  always_comb begin
    w_g_wsize = '0;
    w_g_waddr = '0;
    w_g_wdata = '0;
    w_g_dsize = '0;
    for (int unsigned r = 0; r < num_req_p; r++) begin
      w_g_wsize = w_g_wsize | (req_wsize_i[r*size_width_lp +: size_width_lp] & {size_width_lp{r_grant[r]}});
      w_g_waddr = w_g_waddr | (req_waddr_i[r*addr_width_lp +: addr_width_lp] & {addr_width_lp{r_grant[r]}});
      w_g_wdata = w_g_wdata | (req_wdata_i[r*data_width_p +: data_width_p] & {data_width_p{r_grant[r]}});
      w_g_dsize = w_g_dsize | (req_wdata_size_i[r*dsize_width_lp +: dsize_width_lp] & {dsize_width_lp{r_grant[r]}});
    end
  end

  assign packet_wsize_valid_o = w_own & w_g_wsize_v & packet_req_i;
  assign packet_wvalid_o      = w_own & w_g_wvalid & packet_req_i;
  assign packet_send_o        = w_own & w_g_send & packet_req_i;
  assign packet_wsize_o       = w_own ? w_g_wsize : '0;
  assign packet_waddr_o       = w_own ? w_g_waddr : '0;
  assign packet_wdata_o       = w_own ? w_g_wdata : '0;
  assign packet_wdata_size_o  = w_own ? w_g_dsize : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_wdog_nxt  = r_wdog;
    w_abort_nxt = 1'b0;
    w_sent_inc  = 1'b0;
    w_arb_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb_en = packet_req_i;
        if (w_arb_valid) begin
          w_state_nxt = OWN;
          w_grant_nxt = w_arb_grant;
          w_ptr_nxt   = w_arb_next_ptr;
          w_wdog_nxt  = '0;
        end
      end
      OWN: begin
        // Send beats both a dropped request and an expiring watchdog.
        if (packet_send_o) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_wdog_nxt  = '0;
          w_sent_inc  = 1'b1;
        end else if (!w_g_req_v || (r_wdog == wd_width_lp'(timeout_p - 1))) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_wdog_nxt  = '0;
          w_abort_nxt = 1'b1;
        end else if (packet_wsize_valid_o || packet_wvalid_o) begin
          w_wdog_nxt  = '0;
        end else begin
          w_wdog_nxt  = r_wdog + wd_width_lp'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_wdog       <= '0;
      r_abort      <= 1'b0;
      r_sent_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_ptr        <= w_ptr_nxt;
      r_wdog       <= w_wdog_nxt;
      r_abort      <= w_abort_nxt;
      r_sent_count <= r_sent_count + 16'(w_sent_inc);
    end
  end

  assign grant_o      = r_grant;
  assign abort_o      = r_abort;
  assign sent_count_o = r_sent_count;

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(r_grant))
    else $error("grant_o is not one-hot");

  a_foreign_strobe: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(w_own && |(w_req_strobe & ~r_grant)))
    else $error("non-grantee strobe while the port is owned");

  a_masked_strobe: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(w_own && |(w_req_strobe & r_grant) && !packet_req_i))
    else $error("grantee strobe while packet_req_i is low");

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Bench for ethernet_tx_arbiter: directed vector table, corner-case sequences and a
// randomized run checked against an owner/pointer/idle-count reference model.
module tb_ethernet_tx_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 11;
  localparam int unsigned SW  = 12;
  localparam int unsigned DSW = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic [NR-1:0]     req_v, grant, wsv, wv, snd;
  logic [NR*SW-1:0]  wsize;
  logic [NR*AW-1:0]  waddr;
  logic [NR*DW-1:0]  wdata;
  logic [NR*DSW-1:0] dsize;
  logic              pr;
  logic              p_wsv, p_wv, p_send, abort;
  logic [SW-1:0]     p_wsize;
  logic [AW-1:0]     p_waddr;
  logic [DW-1:0]     p_wdata;
  logic [DSW-1:0]    p_dsize;
  logic [15:0]       sent;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ethernet_tx_arbiter #(
    .num_req_p(NR), .data_width_p(DW), .eth_mtu_p(2048), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .req_v_i(req_v), .grant_o(grant),
    .req_wsize_valid_i(wsv), .req_wsize_i(wsize),
    .req_wvalid_i(wv), .req_waddr_i(waddr), .req_wdata_i(wdata),
    .req_wdata_size_i(dsize), .req_send_i(snd),
    .packet_req_i(pr),
    .packet_wsize_valid_o(p_wsv), .packet_wsize_o(p_wsize),
    .packet_wvalid_o(p_wv), .packet_waddr_o(p_waddr), .packet_wdata_o(p_wdata),
    .packet_wdata_size_o(p_dsize), .packet_send_o(p_send),
    .abort_o(abort), .sent_count_o(sent)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        pr;
    logic [1:0]  wsv, wv, snd;
    logic [1:0]  e_grant;
    logic        e_wsv, e_wv, e_send, e_abort;
    logic [15:0] e_sent;
    logic [11:0] e_wsize;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl [12];

  // reference model state
  int m_owner, m_ptr, m_idle, m_sent;
  bit m_abort;

  initial begin
    #2_000_000;
    $display("FAIL time_limit: got no finish expected finish before 2ms");
    $fatal(1, "bench time limit");
  end

  initial begin
    tbl[0]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 12'd0,   32'h0};
    tbl[1]  = '{2'b11, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 12'd60,  32'hAAAA_0000};
    tbl[2]  = '{2'b11, 1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 12'd60,  32'hAAAA_0000};
    tbl[3]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 12'd60,  32'hAAAA_0000};
    tbl[4]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 12'd60,  32'hAAAA_0000};
    tbl[5]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 12'd0,   32'h0};
    tbl[6]  = '{2'b11, 1'b1, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 12'd100, 32'hBBBB_1111};
    tbl[7]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 12'd100, 32'hBBBB_1111};
    tbl[8]  = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 12'd0,   32'h0};
    tbl[9]  = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 12'd60,  32'hAAAA_0000};
    tbl[10] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 12'd0,   32'h0};
    tbl[11] = '{2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 12'd0,   32'h0};

    reset_n = 1'b0;
    req_v = '0; wsv = '0; wv = '0; snd = '0; pr = 1'b0;
    wsize = {12'd100, 12'd60};
    waddr = {11'h20, 11'h10};
    wdata = {32'hBBBB_1111, 32'hAAAA_0000};
    dsize = {2'd2, 2'd2};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_abort", 64'(abort), 64'h0);
    chk("rst_sent", 64'(sent), 64'h0);
    chk("rst_wdata", 64'(p_wdata), 64'h0);
    chk("rst_wsize", 64'(p_wsize), 64'h0);
    chk("rst_waddr", 64'(p_waddr), 64'h0);
    reset_n = 1'b1;

    // directed table: grant order, masking, send and request-drop aborts
    for (int i = 0; i < 12; i++) begin
      req_v = tbl[i].req; pr = tbl[i].pr;
      wsv = tbl[i].wsv; wv = tbl[i].wv; snd = tbl[i].snd;
      #4;
      chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_wsv", i),   64'(p_wsv),  64'(tbl[i].e_wsv));
      chk($sformatf("tbl%0d_wv", i),    64'(p_wv),   64'(tbl[i].e_wv));
      chk($sformatf("tbl%0d_send", i),  64'(p_send), 64'(tbl[i].e_send));
      chk($sformatf("tbl%0d_abort", i), 64'(abort),  64'(tbl[i].e_abort));
      chk($sformatf("tbl%0d_sent", i),  64'(sent),   64'(tbl[i].e_sent));
      chk($sformatf("tbl%0d_wsize", i), 64'(p_wsize), 64'(tbl[i].e_wsize));
      chk($sformatf("tbl%0d_wdata", i), 64'(p_wdata), 64'(tbl[i].e_wdata));
      tick();
    end

    // watchdog: req1 granted, idles TO cycles, revoked, req0 granted next
    req_v = 2'b11; pr = 1'b1; wsv = '0; wv = '0; snd = '0;
    #4; chk("wd_idle_grant", 64'(grant), 64'h0);
    tick();
    for (int k = 0; k < TO; k++) begin
      #4;
      chk($sformatf("wd_own%0d_grant", k), 64'(grant), 64'h2);
      chk($sformatf("wd_own%0d_abort", k), 64'(abort), 64'h0);
      tick();
    end
    #4;
    chk("wd_revoke_grant", 64'(grant), 64'h0);
    chk("wd_revoke_abort", 64'(abort), 64'h1);
    tick();
    #4;
    chk("wd_regrant", 64'(grant), 64'h1);
    chk("wd_regrant_abort", 64'(abort), 64'h0);
    tick();

    // send on the last watchdog cycle: send wins, no abort
    for (int k = 1; k < TO - 1; k++) begin
      #4; chk($sformatf("ws_own%0d_grant", k), 64'(grant), 64'h1);
      tick();
    end
    snd = 2'b01;
    #4;
    chk("ws_send", 64'(p_send), 64'h1);
    chk("ws_send_grant", 64'(grant), 64'h1);
    tick();
    snd = '0;
    #4;
    chk("ws_after_grant", 64'(grant), 64'h0);
    chk("ws_after_abort", 64'(abort), 64'h0);
    chk("ws_after_sent", 64'(sent), 64'd2);
    tick();

    // 60-byte packet from req1 while req0 wiggles its payload without strobes
    wsv = 2'b10; wsize = {12'd60, 12'hABC};
    #4;
    chk("pkt_grant", 64'(grant), 64'h2);
    chk("pkt_wsv", 64'(p_wsv), 64'h1);
    chk("pkt_wsize", 64'(p_wsize), 64'd60);
    tick();
    wsv = '0;
    for (int i = 0; i < 15; i++) begin
      wv = 2'b10;
      waddr = {11'(4 * i), 11'($urandom)};
      wdata = {32'hD000_0000 + 32'(i), $urandom};
      dsize = {2'd2, 2'($urandom)};
      #4;
      chk($sformatf("pkt_w%0d_wv", i), 64'(p_wv), 64'h1);
      chk($sformatf("pkt_w%0d_addr", i), 64'(p_waddr), 64'(4 * i));
      chk($sformatf("pkt_w%0d_data", i), 64'(p_wdata), 64'(32'hD000_0000 + 32'(i)));
      chk($sformatf("pkt_w%0d_dsize", i), 64'(p_dsize), 64'd2);
      tick();
    end
    wv = '0; snd = 2'b10;
    #4; chk("pkt_send", 64'(p_send), 64'h1);
    tick();
    snd = '0;
    #4;
    chk("pkt_done_grant", 64'(grant), 64'h0);
    chk("pkt_done_sent", 64'(sent), 64'd3);
    chk("pkt_done_abort", 64'(abort), 64'h0);
    tick();

    // asynchronous reset in the middle of req0's packet
    wv = 2'b01;
    #4;
    chk("ar_grant", 64'(grant), 64'h1);
    chk("ar_wv", 64'(p_wv), 64'h1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("ar_rst_grant", 64'(grant), 64'h0);
    chk("ar_rst_wv", 64'(p_wv), 64'h0);
    chk("ar_rst_sent", 64'(sent), 64'h0);
    wv = '0;
    tick(); tick();
    reset_n = 1'b1; req_v = 2'b11; pr = 1'b1;
    #4; chk("ar_post_idle", 64'(grant), 64'h0);
    tick();
    #4; chk("ar_post_grant", 64'(grant), 64'h1);
    tick();

    // randomized run against the reference model
    reset_n = 1'b0; req_v = '0; wsv = '0; wv = '0; snd = '0;
    tick(); tick();
    reset_n = 1'b1;
    m_owner = -1; m_ptr = 0; m_idle = 0; m_sent = 0; m_abort = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int sp, spd;
      logic [1:0] e_grant;
      bit nxt_abort;
      case ((cyc / 256) % 3)
        0:       begin sp = 40; spd = 8; end
        1:       begin sp = 5;  spd = 2; end
        default: begin sp = 0;  spd = 0; end
      endcase
      pr = ($urandom_range(0, 9) != 0);
      for (int r = 0; r < NR; r++)
        req_v[r] = (r == m_owner) ? ($urandom_range(0, 99) >= 3) : 1'($urandom_range(0, 1));
      wsize = 24'($urandom); waddr = 22'($urandom);
      wdata = {$urandom, $urandom}; dsize = 4'($urandom);
      wsv = '0; wv = '0; snd = '0;
      if (m_owner >= 0 && pr) begin
        wsv[m_owner] = ($urandom_range(0, 99) < sp / 4);
        wv[m_owner]  = ($urandom_range(0, 99) < sp);
        snd[m_owner] = ($urandom_range(0, 99) < spd);
      end
      e_grant = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
      #4;
      chk("rnd_grant", 64'(grant), 64'(e_grant));
      chk("rnd_abort", 64'(abort), 64'(m_abort));
      chk("rnd_sent", 64'(sent), 64'(16'(m_sent)));
      if (m_owner >= 0) begin
        chk("rnd_wsv", 64'(p_wsv), 64'(pr & wsv[m_owner]));
        chk("rnd_wv", 64'(p_wv), 64'(pr & wv[m_owner]));
        chk("rnd_send", 64'(p_send), 64'(pr & snd[m_owner]));
        chk("rnd_wsize", 64'(p_wsize), 64'(wsize[m_owner*SW +: SW]));
        chk("rnd_waddr", 64'(p_waddr), 64'(waddr[m_owner*AW +: AW]));
        chk("rnd_wdata", 64'(p_wdata), 64'(wdata[m_owner*DW +: DW]));
        chk("rnd_dsize", 64'(p_dsize), 64'(dsize[m_owner*DSW +: DSW]));
      end else begin
        chk("rnd_idle_strobes", 64'({p_wsv, p_wv, p_send}), 64'h0);
        chk("rnd_idle_data", 64'({p_wsize, p_waddr, p_wdata, p_dsize}), 64'h0);
      end
      nxt_abort = 1'b0;
      if (m_owner < 0) begin
        if (pr && req_v != '0) begin
          for (int k = 0; k < NR; k++) begin
            if (m_owner < 0 && req_v[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
          end
          m_ptr = (m_owner + 1) % NR;
          m_idle = 0;
        end
      end else if (pr && snd[m_owner]) begin
        m_owner = -1; m_sent++;
      end else if (!req_v[m_owner] || m_idle == TO - 1) begin
        m_owner = -1; nxt_abort = 1'b1;
      end else if (pr && (wsv[m_owner] || wv[m_owner])) begin
        m_idle = 0;
      end else begin
        m_idle++;
      end
      m_abort = nxt_abort;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
